// File: rtl/ct_idu_rf_prf_gated_vreg_mp.sv
// Single vector PRF entry with multi-port byte-masked writeback, ready/error tracking
// and an optional registered write stage, clocked through a local clock gate.

module gated_clk_cell (
    input  logic clk_in,
    input  logic global_en,
    input  logic module_en,
    input  logic local_en,
    input  logic external_en,
    input  logic pad_yy_icg_scan_en,
    output logic clk_out
);
    logic w_en_bf_latch;
    logic r_en_af_latch;

    assign w_en_bf_latch = (global_en & (module_en | local_en)) | external_en;

    // Enable is captured while the clock is low so the gated clock never glitches.
    always_latch begin
        if (!clk_in)
            r_en_af_latch = w_en_bf_latch | pad_yy_icg_scan_en;
    end

    assign clk_out = clk_in & r_en_af_latch;
endmodule

module ct_idu_rf_prf_gated_vreg_mp #(
    parameter int VEC_WIDTH = 64,
    parameter int WB_PORTS  = 3,
    parameter int PIPE_WB   = 0
) (
    input  logic                            vreg_top_clk,
    input  logic                            cpurst,
    input  logic                            cp0_idu_icg_en,
    input  logic                            cp0_yy_clk_en,
    input  logic                            pad_yy_icg_scan_en,
    input  logic [WB_PORTS-1:0]             x_wb_vld,
    input  logic [WB_PORTS*VEC_WIDTH-1:0]   x_wb_data,
    input  logic [WB_PORTS*VEC_WIDTH/8-1:0] x_wb_bmask,
    input  logic                            x_alloc,
    output logic [VEC_WIDTH-1:0]            x_reg_dout,
    output logic                            x_reg_rdy,
    output logic                            x_wb_err
);
    localparam int NB = VEC_WIDTH / 8;

    logic                 w_gclk;
    logic                 w_local_en;
    logic                 w_any_wb;
    logic                 w_collide;
    logic                 w_found;
    logic [VEC_WIDTH-1:0] w_sel_data;
    logic [NB-1:0]        w_sel_bmask;
    logic                 w_stg_vld;
    logic                 w_cm_vld;
    logic [VEC_WIDTH-1:0] w_cm_data;
    logic [NB-1:0]        w_cm_bmask;
    logic [VEC_WIDTH-1:0] w_cm_mbits;

    logic [VEC_WIDTH-1:0] r_entry;
    logic                 r_rdy;
    logic                 r_err;

    assign w_any_wb = |x_wb_vld;

    // Lowest-index valid port wins; any further valid port flags a collision.
    always_comb begin
        w_sel_data  = '0;
        w_sel_bmask = '0;
        w_collide   = 1'b0;
        w_found     = 1'b0;
        for (int p = 0; p < WB_PORTS; p++) begin
            if (x_wb_vld[p]) begin
                if (w_found) begin
                    w_collide = 1'b1;
                end else begin
                    w_found     = 1'b1;
                    w_sel_data  = x_wb_data[p*VEC_WIDTH +: VEC_WIDTH];
                    w_sel_bmask = x_wb_bmask[p*NB +: NB];
                end
            end
        end
    end

    generate
        if (PIPE_WB != 0) begin : g_pipe
            logic                 r_stg_vld;
            logic [VEC_WIDTH-1:0] r_stg_data;
            logic [NB-1:0]        r_stg_bmask;

            always_ff @(posedge w_gclk or posedge cpurst) begin
                if (cpurst) begin
                    r_stg_vld   <= 1'b0;
                    r_stg_data  <= '0;
                    r_stg_bmask <= '0;
                end else begin
                    r_stg_vld <= w_any_wb;
                    if (w_any_wb) begin
                        r_stg_data  <= w_sel_data;
                        r_stg_bmask <= w_sel_bmask;
                    end
                end
            end

            assign w_stg_vld  = r_stg_vld;
            assign w_cm_vld   = r_stg_vld;
            assign w_cm_data  = r_stg_data;
            assign w_cm_bmask = r_stg_bmask;
        end else begin : g_direct
            assign w_stg_vld  = 1'b0;
            assign w_cm_vld   = w_any_wb;
            assign w_cm_data  = w_sel_data;
            assign w_cm_bmask = w_sel_bmask;
        end
    endgenerate

    for (genvar b = 0; b < NB; b++) begin : g_mask
        assign w_cm_mbits[b*8 +: 8] = {8{w_cm_bmask[b]}};
    end

    assign w_local_en = w_any_wb | x_alloc | w_stg_vld | (w_any_wb & w_collide);

    gated_clk_cell x_gated_clk (
        .clk_in             (vreg_top_clk),
        .global_en          (cp0_yy_clk_en),
        .module_en          (cp0_idu_icg_en),
        .local_en           (w_local_en),
        .external_en        (1'b0),
        .pad_yy_icg_scan_en (pad_yy_icg_scan_en),
        .clk_out            (w_gclk)
    );

    // A commit that coincides with alloc is a stale writeback: data lands, ready stays low.
    always_ff @(posedge w_gclk or posedge cpurst) begin
        if (cpurst) begin
            r_entry <= '0;
            r_rdy   <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            if (w_cm_vld)
                r_entry <= (r_entry & ~w_cm_mbits) | (w_cm_data & w_cm_mbits);
            if (x_alloc)
                r_rdy <= 1'b0;
            else if (w_cm_vld)
                r_rdy <= 1'b1;
            if (w_collide | (w_cm_vld & x_alloc))
                r_err <= 1'b1;
        end
    end

    assign x_reg_dout = r_entry;
    assign x_reg_rdy  = r_rdy;
    assign x_wb_err   = r_err;
endmodule

// File: tb/tb_ct_idu_rf_prf_gated_vreg_mp.sv
// Drives one direct-write and one pipelined-write instance with shared stimulus
// and compares both against a byte-level reference model.

module tb_ct_idu_rf_prf_gated_vreg_mp;
    logic        clk = 1'b0;
    logic        cpurst;
    logic        icg_en;
    logic        glb_en;
    logic        scan_en;
    logic [2:0]  t_vld;
    logic [63:0] t_data [3];
    logic [7:0]  t_mask [3];
    logic        t_alloc;

    logic [191:0] wb_data;
    logic [23:0]  wb_mask;
    logic [63:0]  d0, d1;
    logic         rdy0, rdy1, err0, err1;

    int tests = 0;
    int fails = 0;
    int g0 = 0;
    int g1 = 0;

    logic [63:0] m_ent [2];
    logic        m_rdy [2];
    logic        m_err [2];
    logic        p_vld;
    logic [63:0] p_data;
    logic [7:0]  p_mask;

    always #5 clk = ~clk;

    assign wb_data = {t_data[2], t_data[1], t_data[0]};
    assign wb_mask = {t_mask[2], t_mask[1], t_mask[0]};

    ct_idu_rf_prf_gated_vreg_mp #(.VEC_WIDTH(64), .WB_PORTS(3), .PIPE_WB(0)) u_p0 (
        .vreg_top_clk(clk), .cpurst(cpurst), .cp0_idu_icg_en(icg_en),
        .cp0_yy_clk_en(glb_en), .pad_yy_icg_scan_en(scan_en),
        .x_wb_vld(t_vld), .x_wb_data(wb_data), .x_wb_bmask(wb_mask), .x_alloc(t_alloc),
        .x_reg_dout(d0), .x_reg_rdy(rdy0), .x_wb_err(err0));

    ct_idu_rf_prf_gated_vreg_mp #(.VEC_WIDTH(64), .WB_PORTS(3), .PIPE_WB(1)) u_p1 (
        .vreg_top_clk(clk), .cpurst(cpurst), .cp0_idu_icg_en(icg_en),
        .cp0_yy_clk_en(glb_en), .pad_yy_icg_scan_en(scan_en),
        .x_wb_vld(t_vld), .x_wb_data(wb_data), .x_wb_bmask(wb_mask), .x_alloc(t_alloc),
        .x_reg_dout(d1), .x_reg_rdy(rdy1), .x_wb_err(err1));

    always @(posedge u_p0.w_gclk) g0++;
    always @(posedge u_p1.w_gclk) g1++;

    function automatic logic [63:0] merge(input logic [63:0] o, input logic [63:0] d,
                                          input logic [7:0] m);
        logic [63:0] r;
        r = o;
        for (int b = 0; b < 8; b++)
            if (m[b]) r[b*8 +: 8] = d[b*8 +: 8];
        return r;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_ent[i] = '0;
            m_rdy[i] = 1'b0;
            m_err[i] = 1'b0;
        end
        p_vld  = 1'b0;
        p_data = '0;
        p_mask = '0;
    endtask

    task automatic model_edge();
        int cnt;
        int w;
        cnt = 0;
        w   = -1;
        for (int p = 0; p < 3; p++)
            if (t_vld[p]) begin
                cnt++;
                if (w < 0) w = p;
            end
        if (w >= 0) begin
            m_ent[0] = merge(m_ent[0], t_data[w], t_mask[w]);
            m_rdy[0] = !t_alloc;
            if (cnt > 1 || t_alloc) m_err[0] = 1'b1;
        end else if (t_alloc) begin
            m_rdy[0] = 1'b0;
        end
        if (p_vld) begin
            m_ent[1] = merge(m_ent[1], p_data, p_mask);
            m_rdy[1] = 1'b1;
        end
        if (t_alloc) m_rdy[1] = 1'b0;
        if (cnt > 1 || (t_alloc && p_vld)) m_err[1] = 1'b1;
        p_vld = (w >= 0);
        if (w >= 0) begin
            p_data = t_data[w];
            p_mask = t_mask[w];
        end
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("dout_p0", d0, m_ent[0]);
        chk("rdy_p0", {63'd0, rdy0}, {63'd0, m_rdy[0]});
        chk("err_p0", {63'd0, err0}, {63'd0, m_err[0]});
        chk("dout_p1", d1, m_ent[1]);
        chk("rdy_p1", {63'd0, rdy1}, {63'd0, m_rdy[1]});
        chk("err_p1", {63'd0, err1}, {63'd0, m_err[1]});
    endtask

    task automatic step(input logic [2:0] v, input logic a);
        t_vld   = v;
        t_alloc = a;
        @(posedge clk);
        model_edge();
        #1;
        check_all();
        t_vld   = '0;
        t_alloc = 1'b0;
    endtask

    task automatic do_reset();
        cpurst = 1'b1;
        model_reset();
        #1;
        check_all();
        @(posedge clk);
        #1;
        cpurst = 1'b0;
    endtask

    int gs0, gs1;

    initial begin
        cpurst  = 1'b1;
        icg_en  = 1'b0;
        glb_en  = 1'b1;
        scan_en = 1'b0;
        t_vld   = '0;
        t_alloc = 1'b0;
        for (int p = 0; p < 3; p++) begin
            t_data[p] = '0;
            t_mask[p] = '0;
        end
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        cpurst = 1'b0;

        gs0 = g0;
        gs1 = g1;
        repeat (5) step(3'b000, 1'b0);
        chk("gclk_idle_p0", 64'(g0 - gs0), 64'd0);
        chk("gclk_idle_p1", 64'(g1 - gs1), 64'd0);

        t_data[1] = 64'h0123_4567_89AB_CDEF;
        t_mask[1] = 8'hFF;
        step(3'b010, 1'b0);
        chk("full_p0", d0, 64'h0123_4567_89AB_CDEF);
        chk("full_p1_early", d1, 64'h0);
        step(3'b000, 1'b0);
        chk("full_p1", d1, 64'h0123_4567_89AB_CDEF);
        chk("full_rdy_p1", {63'd0, rdy1}, 64'd1);
        chk("gclk_run", {63'd0, (g0 > gs0)}, 64'd1);

        t_data[0] = '1;
        t_mask[0] = 8'hFF;
        step(3'b001, 1'b0);
        step(3'b000, 1'b0);
        t_data[0] = '0;
        t_mask[0] = 8'h0F;
        step(3'b001, 1'b0);
        step(3'b000, 1'b0);
        chk("partial_p0", d0, 64'hFFFF_FFFF_0000_0000);
        chk("partial_p1", d1, 64'hFFFF_FFFF_0000_0000);

        t_data[0] = '1;
        t_mask[0] = 8'hFF;
        step(3'b001, 1'b0);
        step(3'b000, 1'b0);
        t_data[0] = 64'h11;
        t_mask[0] = 8'h01;
        step(3'b001, 1'b0);
        t_data[2] = 64'h2200;
        t_mask[2] = 8'h02;
        step(3'b100, 1'b0);
        step(3'b000, 1'b0);
        chk("b2b_p0", d0, 64'hFFFF_FFFF_FFFF_2211);
        chk("b2b_p1", d1, 64'hFFFF_FFFF_FFFF_2211);

        step(3'b000, 1'b1);
        chk("alloc_rdy_p0", {63'd0, rdy0}, 64'd0);
        chk("alloc_hold_p1", d1, 64'hFFFF_FFFF_FFFF_2211);
        t_data[0] = 64'h55;
        t_mask[0] = 8'hFF;
        step(3'b001, 1'b1);
        chk("stale_dout_p0", d0, 64'h55);
        chk("stale_err_p0", {63'd0, err0}, 64'd1);
        step(3'b000, 1'b1);
        chk("stale_dout_p1", d1, 64'h55);
        chk("stale_err_p1", {63'd0, err1}, 64'd1);

        do_reset();
        t_data[0] = 64'hA;
        t_data[2] = 64'hB;
        t_mask[0] = 8'hFF;
        t_mask[2] = 8'hFF;
        step(3'b101, 1'b0);
        step(3'b000, 1'b0);
        chk("coll_dout_p0", d0, 64'hA);
        chk("coll_dout_p1", d1, 64'hA);
        chk("coll_err_p1", {63'd0, err1}, 64'd1);
        t_data[1] = 64'h77;
        t_mask[1] = 8'hFF;
        step(3'b010, 1'b0);
        step(3'b000, 1'b0);
        chk("coll_sticky_p0", {63'd0, err0}, 64'd1);

        do_reset();
        for (int i = 0; i < 400; i++) begin
            for (int p = 0; p < 3; p++) begin
                t_data[p] = {$urandom, $urandom};
                t_mask[p] = 8'($urandom);
            end
            icg_en = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 9) < 4)
                step(3'b000, ($urandom_range(0, 5) == 0));
            else
                step(3'($urandom_range(1, 7)), ($urandom_range(0, 5) == 0));
        end
        icg_en = 1'b0;

        t_data[1] = 64'hDEAD_BEEF_CAFE_F00D;
        t_mask[1] = 8'hFF;
        step(3'b010, 1'b0);
        cpurst = 1'b1;
        model_reset();
        #1;
        chk("arst_dout_p0", d0, 64'h0);
        chk("arst_dout_p1", d1, 64'h0);
        @(posedge clk);
        #1;
        cpurst = 1'b0;
        repeat (3) step(3'b000, 1'b0);
        chk("arst_nolate_p1", d1, 64'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/ct_idu_rf_prf_gated_vreg_mp.md
Name: ct_idu_rf_prf_gated_vreg_mp

Overview:
- Parametrised successor to the single-entry gated vector physical register.
- Holds one vector PRF entry of VEC_WIDTH bits. It is written by WB_PORTS one-hot writeback ports, each carrying a per-byte write mask.
- Tracks a ready bit for rename/issue, detects multi-port write collisions, and has an optional registered write stage for timing.
- Sits in the IDU RF next to the scalar/vector PRF array. Its write clock is gated through the standard gated_clk_cell.

Parameters:
- VEC_WIDTH, 64, entry width in bits; must be a multiple of 8.
- WB_PORTS, 3, number of writeback ports.
- PIPE_WB, 0, 0 = write lands at the next edge; 1 = one extra registered stage before the entry.

Ports:
- vreg_top_clk  in  1  ungated top clock.
- cpurst  in  1  asynchronous active-high reset.
- cp0_idu_icg_en  in  1  module ICG enable.
- cp0_yy_clk_en  in  1  global ICG enable.
- pad_yy_icg_scan_en  in  1  scan ICG enable.
- x_wb_vld  in  WB_PORTS  per-port write valid.
- x_wb_data  in  WB_PORTS*VEC_WIDTH  port p data at bits [p*VEC_WIDTH +: VEC_WIDTH].
- x_wb_bmask  in  WB_PORTS*VEC_WIDTH/8  port p byte mask; bit b covers data byte b.
- x_alloc  in  1  rename allocates this entry to a new producer; clears ready.
- x_reg_dout  out  VEC_WIDTH  stored entry value.
- x_reg_rdy  out  1  entry holds a completed result.
- x_wb_err  out  1  sticky collision/protocol error flag.

Behaviour:
- Reset: cpurst high asynchronously clears the entry (x_reg_dout=0), x_reg_rdy=0, x_wb_err=0, and the write-stage valid bit. Reset mid-write discards the staged write.
- Port select: any_wb = |x_wb_vld. If more than one port is valid, the lowest-index valid port wins, its data and mask are used, and x_wb_err is set on the next edge.
- Byte merge: the mask is expanded 8x to bits. new = (old & ~m) | (wdata & m). A zero mask with vld=1 leaves data unchanged but still sets ready.
- PIPE_WB=0: at edge E with any_wb, the merge is done against the current entry. x_reg_dout and x_reg_rdy update at E, so latency is 1 cycle.
- PIPE_WB=1: at edge E, data, mask and winner are captured into the stage (stg_vld=1). At E+1 the merge into the entry is done using the entry value at E+1, so back-to-back partial writes both take effect in order. Latency is 2 cycles.
- Under PIPE_WB=1, the collision check is done at capture and the error is set at E.
- Ready: set when a write commits to the entry; cleared at the edge where x_alloc=1.
- Alloc vs. write, same commit edge: data is still written, x_reg_rdy ends 0, and x_wb_err is set (stale writeback).
- x_wb_err clears only on reset.
- Clock gating:
  - Instantiate gated_clk_cell with clk_in=vreg_top_clk, external_en=1'b0, global_en=cp0_yy_clk_en, module_en=cp0_idu_icg_en, pad_yy_icg_scan_en passed through.
  - local_en = any_wb | x_alloc | stg_vld | (any_wb with collision).
  - The entry, ready bit, error flag and stage all run on the gated clock; the async reset bypasses gating.
- No-write cycle: all state holds.
- Outputs come straight from flops; there is no combinational path from x_wb_* to outputs.

Test Plan:
- Reset then idle, PIPE_WB=0: x_reg_dout=0, rdy=0, err=0. Confirm the gated clock does not toggle while local_en=0.
- Full write: port1 vld, data=0x0123_4567_89AB_CDEF, mask=0xFF. Next edge: dout equals the data, rdy=1. With PIPE_WB=1 the same result appears one edge later.
- Partial merge: entry=0xFFFF_FFFF_FFFF_FFFF; port0 data=0, mask=0x0F gives 0xFFFF_FFFF_0000_0000. With PIPE_WB=1, two back-to-back writes (port0 mask 0x01 data=0x11, then port2 mask 0x02 data=0x2200) end at 0x...2211 with upper bytes preserved.
- Collision: ports 0 and 2 valid in one cycle with data 0xA and 0xB, full mask. Result: dout=0xA, err=1, and err stays 1 through later clean writes.
- Alloc: rdy=1, pulse x_alloc gives rdy=0 and dout held. x_alloc together with a write of 0x55 gives dout=0x55, rdy=0, err=1.
- Async reset: with PIPE_WB=1, assert cpurst between capture and commit. Outputs go to 0 immediately and the staged write never lands after reset is released.
